// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule: one 32-bit schedule word per cycle,
// 128-bit round keys delivered over a valid/ready stream with backpressure.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   // Entry 0 sits at the MSBs, so the byte for input a starts at bit 8*(255-a).
   assign y = SBOX_TABLE[{~a, 3'b000} +: 8];
endmodule

module aes_key_expander #(
   parameter int KEY_W = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       key_len,
   input  logic [KEY_W-1:0] key_in,
   output logic             busy,
   output logic             rk_valid,
   input  logic             rk_ready,
   output logic [127:0]     rk_data,
   output logic [3:0]       rk_idx,
   output logic             rk_last,
   output logic             done,
   output logic             err
);
   typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [1:0]       len_q, len_d;
   logic [5:0]       t_q, t_d;
   logic [2:0]       k_q, k_d;
   logic [7:0]       rcon_q, rcon_d;
   logic [7:0][31:0] win_q, win_d;
   logic             rk_valid_q, rk_valid_d, rk_last_q, rk_last_d;
   logic [127:0]     rk_data_q, rk_data_d;
   logic [3:0]       rk_idx_q, rk_idx_d;
   logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic [3:0]  nk, nk_in;
   logic [5:0]  last_t;
   logic        in_legal, stall;
   logic [31:0] w_prev, w_nk, sub_in, sub_out, w_new;

   function automatic logic [3:0] nk_of(input logic [1:0] len);
      case (len)
         2'b00:   return 4'd4;
         2'b01:   return 4'd6;
         default: return 4'd8;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   assign nk       = nk_of(len_q);
   assign nk_in    = nk_of(key_len);
   assign in_legal = (key_len != 2'b11) && ((32 * int'(nk_in)) <= KEY_W);
   // Last word index is 4*Nr+3 with Nr = Nk+6.
   assign last_t   = (len_q == 2'b00) ? 6'd43 : (len_q == 2'b01) ? 6'd51 : 6'd59;
   assign w_prev   = win_q[7];
   assign stall    = (t_q[1:0] == 2'b11) && rk_valid_q && !rk_ready;

   always_comb begin
      case (len_q)
         2'b00:   w_nk = win_q[4];
         2'b01:   w_nk = win_q[2];
         default: w_nk = win_q[0];
      endcase
   end

   // The same S-box bank serves RotWord+SubWord and the AES-256 mid-block SubWord.
   assign sub_in = (k_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (.a(sub_in[8*i +: 8]), .y(sub_out[8*i +: 8]));
   end

   always_comb begin
      if (t_q < {2'b00, nk})
         w_new = key_q[KEY_W-1 -: 32];
      else if (k_q == 3'd0)
         w_new = w_nk ^ sub_out ^ {rcon_q, 24'h0};
      else if (len_q == 2'b10 && k_q == 3'd4)
         w_new = w_nk ^ sub_out;
      else
         w_new = w_nk ^ w_prev;
   end

   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      len_d      = len_q;
      t_d        = t_q;
      k_d        = k_q;
      rcon_d     = rcon_q;
      win_d      = win_q;
      rk_valid_d = rk_valid_q;
      rk_last_d  = rk_last_q;
      rk_data_d  = rk_data_q;
      rk_idx_d   = rk_idx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      if (rk_valid_q && rk_ready) begin
         rk_valid_d = 1'b0;
         rk_last_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               if (in_legal) begin
                  state_d = GEN;
                  key_d   = key_in;
                  len_d   = key_len;
                  t_d     = 6'd0;
                  k_d     = 3'd0;
                  rcon_d  = 8'h01;
                  busy_d  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         GEN: begin
            if (!stall) begin
               win_d = {w_new, win_q[7:1]};
               key_d = key_q << 32;
               t_d   = t_q + 6'd1;
               k_d   = ({1'b0, k_q} == nk - 4'd1) ? 3'd0 : k_q + 3'd1;
               if (t_q >= {2'b00, nk} && k_q == 3'd0)
                  rcon_d = xtime(rcon_q);
               if (t_q[1:0] == 2'b11) begin
                  rk_data_d  = {win_q[5], win_q[6], win_q[7], w_new};
                  rk_idx_d   = t_q[5:2];
                  rk_valid_d = 1'b1;
                  rk_last_d  = (t_q == last_t);
               end
               if (t_q == last_t)
                  state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (rk_valid_q && rk_ready) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         key_q      <= '0;
         len_q      <= '0;
         t_q        <= '0;
         k_q        <= '0;
         rcon_q     <= '0;
         win_q      <= '0;
         rk_valid_q <= 1'b0;
         rk_last_q  <= 1'b0;
         rk_data_q  <= '0;
         rk_idx_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         len_q      <= len_d;
         t_q        <= t_d;
         k_q        <= k_d;
         rcon_q     <= rcon_d;
         win_q      <= win_d;
         rk_valid_q <= rk_valid_d;
         rk_last_q  <= rk_last_d;
         rk_data_q  <= rk_data_d;
         rk_idx_q   <= rk_idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign busy     = busy_q;
   assign rk_valid = rk_valid_q;
   assign rk_data  = rk_data_q;
   assign rk_idx   = rk_idx_q;
   assign rk_last  = rk_last_q;
   assign done     = done_q;
   assign err      = err_q;
endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander: a FIPS-197 style reference schedule feeds
// an expected-key queue, and a monitor checks every accepted round key.
module tb_aes_key_expander;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   key_len = 2'b00;
   logic [255:0] key_in = '0;
   logic         rk_ready = 1'b1;
   logic         busy, rk_valid, rk_last, done, err;
   logic [127:0] rk_data;
   logic [3:0]   rk_idx;

   aes_key_expander #(.KEY_W(256)) dut (
      .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
      .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
      .rk_idx(rk_idx), .rk_last(rk_last), .done(done), .err(err)
   );

   typedef struct {
      logic [127:0] data;
      logic [3:0]   idx;
      logic         last;
      int           cyc;
   } exp_t;

   exp_t         exp_q[$];
   int           cyc, n_tests, n_fail, start_cyc, err_count;
   logic         ready_rand = 1'b0;
   logic         hold_pending = 1'b0;
   logic [127:0] hold_data;
   logic [3:0]   hold_idx;
   logic [127:0] got [0:15];
   logic [127:0] mrk [0:14];
   logic [7:0]   sbt [0:255];

   localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      #1;
      rk_ready = ready_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int c = 1; c < 256; c++)
            if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
         sbt[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sbt[x[31:24]], sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]]};
   endfunction

   task automatic build_model(input int nk, input logic [255:0] key);
      logic [31:0] w [0:59];
      logic [31:0] tmp;
      logic [7:0]  rc;
      int          nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) begin
            tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            tmp = subw(tmp);
         end
         w[i] = w[i-nk] ^ tmp;
      end
      for (int r = 0; r <= nr; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         if (err) err_count++;
         if (rk_valid) begin
            if (hold_pending) begin
               check("stall_data_stable", rk_data, hold_data);
               check("stall_idx_stable", 128'(rk_idx), 128'(hold_idx));
            end
            if (rk_ready) begin
               hold_pending = 1'b0;
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_rk: idx %0d data %0h with nothing outstanding", rk_idx, rk_data);
               end else begin
                  e = exp_q.pop_front();
                  check("rk_data", rk_data, e.data);
                  check("rk_idx", 128'(rk_idx), 128'(e.idx));
                  check("rk_last", 128'(rk_last), 128'(e.last));
                  if (e.cyc >= 0) check("rk_cycle", 128'(cyc - start_cyc), 128'(e.cyc));
                  got[rk_idx] = rk_data;
               end
            end else begin
               hold_pending = 1'b1;
               hold_data    = rk_data;
               hold_idx     = rk_idx;
            end
         end
      end
   end

   task automatic run(input logic [1:0] len, input logic [255:0] key, input bit timed,
                      input int inject_at, input int rst_at);
      int nk, nr, rel, err0;
      bit fin;
      nk = (len == 2'b00) ? 4 : (len == 2'b01) ? 6 : 8;
      nr = nk + 6;
      build_model(nk, key);
      for (int r = 0; r < 16; r++) got[r] = '0;
      for (int r = 0; r <= nr; r++)
         exp_q.push_back('{mrk[r], 4'(r), (r == nr), timed ? 4*r + 5 : -1});
      err0 = err_count;
      @(posedge clk); #1;
      start = 1'b1; key_len = len; key_in = key; start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("busy_cycle1", 128'(busy), 128'(1));
      fin = 1'b0;
      for (int i = 0; i < 3000 && !fin; i++) begin
         @(negedge clk);
         rel = cyc - start_cyc;
         if (rel == inject_at) begin
            start = 1'b1; key_len = 2'b11; key_in = {8{$urandom()}};
         end else begin
            start = 1'b0;
         end
         if (rel == rst_at) rst = 1'b1;
         if (rst_at >= 0 && rel == rst_at + 1) begin
            check("rst_ctrl_zero", 128'({busy, rk_valid, rk_idx, rk_last, done, err}), 128'(0));
            check("rst_data_zero", rk_data, 128'(0));
            rst = 1'b0;
            exp_q.delete();
            hold_pending = 1'b0;
            fin = 1'b1;
         end else if (done) begin
            fin = 1'b1;
            if (timed) check("done_cycle", 128'(rel), 128'(4*nr + 6));
            check("busy_low_at_done", 128'(busy), 128'(0));
         end
      end
      if (!fin) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout: no done within 3000 cycles, %0d keys outstanding", exp_q.size());
         exp_q.delete();
      end else if (rst_at < 0) begin
         check("all_keys_seen", 128'(exp_q.size()), 128'(0));
         check("no_err_during_run", 128'(err_count - err0), 128'(0));
      end
   endtask

   initial begin
      build_sbox();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl", 128'({busy, rk_valid, rk_idx, rk_last, done, err}), 128'(0));
      check("reset_data", rk_data, 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      run(2'b00, {K128, 128'h0}, 1'b1, -1, -1);
      check("aes128_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
      check("aes128_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      run(2'b01, {K192, 64'h0}, 1'b1, -1, -1);
      check("aes192_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);

      run(2'b10, K256, 1'b1, -1, -1);
      check("aes256_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

      ready_rand = 1'b1;
      run(2'b10, K256, 1'b0, -1, -1);
      check("aes256_bp_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);
      for (int n = 0; n < 6; n++)
         run(2'($urandom_range(0, 2)), {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, -1, -1);
      ready_rand = 1'b0;

      @(posedge clk); #1;
      start = 1'b1; key_len = 2'b11; start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("illegal_err_cycle1", 128'(err), 128'(1));
      check("illegal_busy_low", 128'(busy), 128'(0));
      @(negedge clk);
      check("illegal_err_one_pulse", 128'(err), 128'(0));

      run(2'b00, {K128, 128'h0}, 1'b1, 10, -1);
      check("inject_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      run(2'b00, {K128, 128'h0}, 1'b0, -1, 20);
      run(2'b00, {K128, 128'h0}, 1'b1, -1, -1);
      check("after_rst_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
      check("after_rst_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Sequential, parameterised AES key-schedule engine that generalises the single-step 128-bit round-key core to AES-128, AES-192 and AES-256, with the mode selected at run time. It accepts a cipher key on a `start` strobe and generates one 32-bit schedule word per cycle. It emits each 128-bit round key over a valid/ready stream with backpressure. It sits between the key register and the round-key store or cipher datapath.

## Interface
- `KEY_W`, default 256. Widest supported key. Legal values are 128, 192 and 256. Any mode wider than `KEY_W` is illegal.
- `clk`, input, 1. The single clock. All state updates on the rising edge.
- `rst`, input, 1. Synchronous, active-high reset.
- `start`, input, 1. Begins an expansion. Sampled only while idle.
- `key_len`, input, 2. Mode select: 00 = 128 (Nk=4, Nr=10), 01 = 192 (Nk=6, Nr=12), 10 = 256 (Nk=8, Nr=14), 11 = illegal.
- `key_in`, input, `KEY_W`. Cipher key, left-aligned. Word 0 is at the MSBs, `key_in[KEY_W-1 -: 32]`. Unused LSBs are ignored.
- `busy`, output, 1. High from the cycle after an accepted `start` until `done`.
- `rk_valid`, output, 1. `rk_data` holds a round key.
- `rk_ready`, input, 1. Consumer accepts the round key.
- `rk_data`, output, 128. Round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in [127:96].
- `rk_idx`, output, 4. Round index r of `rk_data`, 0..Nr.
- `rk_last`, output, 1. High with `rk_valid` when r = Nr.
- `done`, output, 1. One-cycle pulse when the expansion completes.
- `err`, output, 1. One-cycle pulse when `start` is rejected because of an illegal mode.

## Operation
- **States.** IDLE, GEN, DRAIN.
  - IDLE goes to GEN on `start` with a legal mode.
  - GEN goes to DRAIN after word 4Nr+3 is generated.
  - DRAIN goes to IDLE on the handshake of the last round key. `done` pulses in the following cycle.
- **Illegal start.** `start` with `key_len`=11, or with Nk·32 > `KEY_W`, stays in IDLE and pulses `err` in the next cycle.
- **Capture on start.** An accepted start captures `key_in`, `key_len`, word counter t=0 and rcon=0x01.
- **Word generation.** GEN produces word t each cycle, t = 0..4Nr+3, into an 8-word sliding window (w[t-8..t-1]).
  - t < Nk: w[t] = key word t.
  - t mod Nk = 0: w[t] = w[t-Nk] ^ SubWord(RotWord(w[t-1])) ^ {rcon, 24'h0}. Then rcon = xtime(rcon), i.e. shift left with reduction 0x1B when the MSB is set.
  - Nk = 8 and t mod 8 = 4: w[t] = w[t-8] ^ SubWord(w[t-1]).
  - Otherwise: w[t] = w[t-Nk] ^ w[t-1].
- **S-box sharing.** One bank of four `sbox` instances is shared by both SubWord cases.
- **Assembly.** A 4-word assembler collects the words. When word 4r+3 is produced, {w[4r..4r+3]} loads into `rk_data`, `rk_idx` becomes r, and `rk_valid` is set.
- **Handshake.** A transfer happens when `rk_valid` and `rk_ready` are both high. `rk_valid` clears unless a new key loads in the same cycle. Data is stable while `rk_valid` is high and `rk_ready` is low.
- **Stall.** If word 4r+3 would be produced while `rk_valid` is high and `rk_ready` is low, the counter, window and rcon all hold. No word is lost or duplicated.
- **Start while busy.** `start` is ignored and `err` is not asserted.
- **Reset.** `rst` in any state returns to IDLE and clears the window, counter and rcon. Every output goes to 0, including `rk_data` and `rk_idx`. A partial schedule is discarded.

## Timing
- `start` is high in cycle 0.
- Word t is registered at the end of cycle t+1.
- With `rk_ready` held high, `rk_valid` for round r is high in cycle 4r+5 only.
- Last round key appears in cycle 45 (128), 53 (192) or 61 (256).
- `done` is in the cycle after the last handshake, and `busy` falls in that same cycle.
- A new `start` is accepted in the cycle after `done`.
- Each stalled cycle adds exactly one cycle of latency.
- `err` is in cycle 1 after an illegal start.

## Test plan
- **AES-128.** Key 2b7e151628aed2a6abf7158809cf4f3c, ready=1 → rk1 = a0fafe1788542cb123a339392a6c7605; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 45 with `rk_last`; `done` at cycle 46.
- **AES-192.** Key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → 13 keys; rk12 = e98ba06f448c773c8ecc720401002202, `rk_idx`=12.
- **AES-256.** Key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → 15 keys; rk14 = fe4890d1e6188d0b046df344706c631e.
- **Backpressure.** Random `rk_ready` (≈30% high) on AES-256 → identical key sequence, `rk_data` stable during stalls, no gaps or repeats in `rk_idx`.
- **Errors and ignored starts.** `key_len`=11 → `err` pulse in cycle 1, `busy` stays 0; `start` mid-run → ignored.
- **Reset mid-run.** `rst` at cycle 20 of AES-128 → all outputs 0 next cycle; a following AES-128 run matches the golden keys.
